// File: rtl/sram_arb_pkg.sv
// Shared definitions for the inst/data SRAM-like arbiter: owner codes,
// default sizing and the layout of one outstanding-transaction record.
package sram_arb_pkg;
  localparam logic OWNER_INST       = 1'b0;
  localparam logic OWNER_DATA       = 1'b1;
  localparam int   OT_DEPTH_DEF     = 4;
  localparam int   STARVE_LIMIT_DEF = 4;

  typedef struct packed {
    logic        owner;
    logic        wr;
    logic [29:0] waddr;
  } ot_entry_t;
endpackage

// File: rtl/sram_order_fifo.sv
// Acceptance-order FIFO of outstanding transactions; exposes every live
// write entry in parallel so the top can block reads that hit a pending write.
module sram_order_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = OT_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  ot_entry_t              push_entry,
  input  logic                   pop,
  output logic                   head_owner,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH-1:0]       wr_vld,
  output logic [DEPTH-1:0][29:0] waddrs
);
  localparam int AW = $clog2(DEPTH);

  ot_entry_t     mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW-1:0] offs;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign head_owner = mem[rd_ptr].owner;

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    offs   = '0;
    wr_vld = '0;
    waddrs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs      = AW'(i) - rd_ptr;
      wr_vld[i] = ({1'b0, offs} < count) && mem[i].wr;
      waddrs[i] = mem[i].waddr;
    end
  end
endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master SRAM-like arbiter (inst/data) onto one slave port with in-order
// response routing, read-after-write hazard blocking and inst anti-starvation.
module sram_like_arbiter
  import sram_arb_pkg::*;
#(
  parameter int OT_DEPTH     = OT_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  output logic        err_unexp
);
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      head_owner;
  logic [OT_DEPTH-1:0]       wr_vld;
  logic [OT_DEPTH-1:0][29:0] waddrs;
  logic                      inst_haz;
  logic                      data_haz;
  logic                      inst_elig;
  logic                      data_elig;
  logic                      grant_inst;
  logic                      grant_data;
  logic                      accept;
  logic                      pop;
  logic [2:0]                starve_cnt;
  logic [31:0]               inst_rdata_q;
  logic [31:0]               data_rdata_q;
  ot_entry_t                 push_entry;

  always_comb begin
    inst_haz = 1'b0;
    data_haz = 1'b0;
    for (int i = 0; i < OT_DEPTH; i++) begin
      if (wr_vld[i] && (waddrs[i] == inst_addr[31:2])) inst_haz = 1'b1;
      if (wr_vld[i] && (waddrs[i] == data_addr[31:2])) data_haz = 1'b1;
    end
  end

  // Only reads are held back by a pending write to the same word.
  assign inst_elig  = resetn & inst_req & ~fifo_full & (inst_wr | ~inst_haz);
  assign data_elig  = resetn & data_req & ~fifo_full & (data_wr | ~data_haz);
  assign grant_inst = inst_elig & (~data_elig | (starve_cnt == STARVE_MAX));
  assign grant_data = data_elig & ~grant_inst;

  always_comb begin
    s_req   = 1'b0;
    s_wr    = 1'b0;
    s_size  = '0;
    s_wstrb = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (grant_inst) begin
      s_req   = 1'b1;
      s_wr    = inst_wr;
      s_size  = inst_size;
      s_wstrb = inst_wstrb;
      s_addr  = inst_addr;
      s_wdata = inst_wdata;
    end else if (grant_data) begin
      s_req   = 1'b1;
      s_wr    = data_wr;
      s_size  = data_size;
      s_wstrb = data_wstrb;
      s_addr  = data_addr;
      s_wdata = data_wdata;
    end
  end

  assign accept       = s_req & s_addr_ok;
  assign inst_addr_ok = accept & grant_inst;
  assign data_addr_ok = accept & grant_data;
  assign push_entry   = '{owner: (grant_data ? OWNER_DATA : OWNER_INST),
                          wr:    s_wr,
                          waddr: s_addr[31:2]};

  assign pop          = resetn & s_data_ok & ~fifo_empty;
  assign inst_data_ok = pop & (head_owner == OWNER_INST);
  assign data_data_ok = pop & (head_owner == OWNER_DATA);
  assign inst_rdata   = inst_data_ok ? s_rdata : inst_rdata_q;
  assign data_rdata   = data_data_ok ? s_rdata : data_rdata_q;

  sram_order_fifo #(.DEPTH(OT_DEPTH)) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (pop),
    .head_owner (head_owner),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .wr_vld     (wr_vld),
    .waddrs     (waddrs)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt   <= '0;
      err_unexp    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      if (inst_data_ok) inst_rdata_q <= s_rdata;
      if (data_data_ok) data_rdata_q <= s_rdata;
      if (s_data_ok && fifo_empty) err_unexp <= 1'b1;
      if (!inst_req || inst_addr_ok)
        starve_cnt <= '0;
      else if (inst_elig && (starve_cnt < STARVE_MAX))
        starve_cnt <= starve_cnt + 3'd1;
    end
  end
endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 Parameter: OT_DEPTH, default 4, maximum outstanding transactions (power of two, 2..8).
REQ-002 Parameter: STARVE_LIMIT, default 4, consecutive inst denials before inst is forced to win.
REQ-003 Port: clk  in  1  clock; all state on posedge clk.
REQ-004 Port: resetn  in  1  reset; synchronous, active-low.
REQ-005 Ports: inst_req/inst_wr  in  1; inst_size  in  2; inst_wstrb  in  4; inst_addr/inst_wdata  in  32; inst_rdata  out  32; inst_addr_ok/inst_data_ok  out  1. Inst SRAM-like master.
REQ-006 Ports: data_req/data_wr  in  1; data_size  in  2; data_wstrb  in  4; data_addr/data_wdata  in  32; data_rdata  out  32; data_addr_ok/data_data_ok  out  1. Data SRAM-like master.
REQ-007 Ports: s_req/s_wr  out  1; s_size  out  2; s_wstrb  out  4; s_addr/s_wdata  out  32; s_rdata  in  32; s_addr_ok/s_data_ok  in  1. Shared SRAM-like slave, toward the AXI bridge.
REQ-008 Port: err_unexp  out  1  sticky flag; s_data_ok arrived with no outstanding transaction.

Function
REQ-009 Masters hold req and request fields stable until the corresponding addr_ok; the arbiter relies on this.
REQ-010 Grant is combinational per cycle: data wins over inst when both are eligible, unless starve_cnt == STARVE_LIMIT, in which case inst wins.
REQ-011 starve_cnt (3 bits) increments when inst_req is eligible and not accepted; clears on inst acceptance or when inst_req is low; saturates at STARVE_LIMIT.
REQ-012 s_req = eligible request of granted master; s_wr/s_size/s_wstrb/s_addr/s_wdata = granted master's fields; all zero when nothing is granted.
REQ-013 Accept = s_req & s_addr_ok; inst_addr_ok/data_addr_ok = accept & grant of that master; never both high.
REQ-014 On accept, push {owner(0=inst,1=data), wr, addr[31:2]} into the order FIFO (depth OT_DEPTH).
REQ-015 FIFO full (count == OT_DEPTH): both masters ineligible, s_req = 0; no bypass of a same-cycle pop.
REQ-016 Hazard: a read (wr=0) is ineligible while any FIFO entry is a write with equal addr[31:2]; the write is still eligible.
REQ-017 On s_data_ok with FIFO non-empty: pop head; raise owner's data_ok in the same cycle (combinational) and drive owner's rdata = s_rdata; the other master's data_ok = 0.
REQ-018 Non-owner rdata holds its last value; rdata outputs are registered copies updated only on own data_ok, with data_ok combinational and rdata forwarded combinationally that cycle.
REQ-019 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-020 s_data_ok with FIFO empty: ignored, no data_ok, err_unexp set to 1 until reset.
REQ-021 Responses return strictly in acceptance order; no reordering across masters.
REQ-022 Pointers wrap modulo OT_DEPTH; count is log2(OT_DEPTH)+1 bits.

Reset
REQ-023 While resetn = 0 at a clock edge: FIFO pointers/count = 0, starve_cnt = 0, err_unexp = 0, inst_rdata/data_rdata registers = 0.
REQ-024 Combinational outputs during reset: s_req = 0, all addr_ok/data_ok = 0, irrespective of inputs.
REQ-025 Reset mid-transaction discards all outstanding entries; subsequent stray s_data_ok sets err_unexp.

Structure
REQ-026 Package sram_arb_pkg holds OWNER_INST/OWNER_DATA constants, default OT_DEPTH, STARVE_LIMIT, and the FIFO entry struct {owner, wr, waddr[29:0]}.
REQ-027 One sub-module: sram_order_fifo (push/pop/full/empty/head plus parallel entry visibility for the hazard check).
REQ-028 No other sub-modules; arbitration, starve counter and response routing live in the top.

Verification
REQ-029 Both reads at once, s_addr_ok=1, data_addr=0x100, inst_addr=0x200 -> data accepted cycle 0, inst accepted cycle 1; data_ok on data then inst, in order.
REQ-030 data_req held high continuously, inst_req high, s_addr_ok=1, no responses pending limit -> inst accepted no later than cycle STARVE_LIMIT (4) after first denial.
REQ-031 Four accepted reads with no s_data_ok -> count=4, s_req=0 next cycle; s_data_ok with push in same cycle on count=3 -> count stays 3.
REQ-032 Data write to 0x1004 outstanding, then inst read 0x1004 -> inst blocked until write's data_ok; inst read 0x1008 in same window accepted.
REQ-033 s_data_ok with empty FIFO -> no data_ok, err_unexp=1, stays 1 until resetn=0.
REQ-034 Reset asserted with 2 outstanding -> after release count=0, s_data_ok produces err_unexp=1 and no data_ok.
